ex_stage: RTL and testbench

- Execute stage of the 5-stage MIPS pipeline. Sits directly downstream of the ID/EX pipeline register and consumes its ex_* outputs.
- Computes single-cycle ALU and link results combinationally.
- Runs DIV/DIVU as a 32-iteration shift-subtract FSM and raises a stall request to the pipeline controller until the quotient and remainder are ready.
- Drives the EX/MEM register with GPR write data and the HI/LO write.

---
 rtl/ex_stage.sv | 170 +++++++++++++++++
 tb/tb_ex_stage.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
// ============================================================================
//  Module   : ex_stage
//  Purpose  : MIPS execute stage: single-cycle ALU/link results plus a
//             32-step restoring DIV/DIVU unit with pipeline stall request.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ex_stage #(
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  aluop_i,
  input  logic [31:0] reg1_i,
  input  logic [31:0] reg2_i,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic [31:0] link_address_i,
  input  logic        is_in_delayslot_i,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic        whilo_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        is_in_delayslot_o,
  output logic        stallreq
);

  localparam logic [7:0] OP_NOP  = 8'h00;
  localparam logic [7:0] OP_OR   = 8'h25;
  localparam logic [7:0] OP_AND  = 8'h24;
  localparam logic [7:0] OP_ADDU = 8'h21;
  localparam logic [7:0] OP_SUBU = 8'h23;
  localparam logic [7:0] OP_SLT  = 8'h2A;
  localparam logic [7:0] OP_JAL  = 8'h50;
  localparam logic [7:0] OP_DIV  = 8'h1A;
  localparam logic [7:0] OP_DIVU = 8'h1B;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [1:0] S_ZERO = 2'd3;

  localparam int CNT_W = 6;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_CYCLES - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      quo_q, quo_d;
  logic [31:0]      rem_q, rem_d;
  logic [31:0]      dvsr_q, dvsr_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;

  logic        is_div;
  logic        is_signed;
  logic [31:0] a_abs;
  logic [31:0] b_abs;
  logic [32:0] shifted;
  logic [32:0] trial;
  logic        fits;

  assign is_div    = (aluop_i == OP_DIV) || (aluop_i == OP_DIVU);
  assign is_signed = (aluop_i == OP_DIV);
  assign a_abs     = (is_signed && reg1_i[31]) ? (~reg1_i + 32'd1) : reg1_i;
  assign b_abs     = (is_signed && reg2_i[31]) ? (~reg2_i + 32'd1) : reg2_i;

  // Partial remainder is always below the divisor, so 33 bits hold the shift.
  assign shifted = {rem_q, quo_q[31]};
  assign trial   = shifted - {1'b0, dvsr_q};
  assign fits    = (shifted >= {1'b0, dvsr_q});

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    dvsr_d    = dvsr_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    case (state_q)
      S_IDLE: begin
        if (is_div) begin
          if (reg2_i != 32'd0) begin
            quo_d     = a_abs;
            rem_d     = 32'd0;
            dvsr_d    = b_abs;
            neg_quo_d = is_signed && (reg1_i[31] ^ reg2_i[31]);
            neg_rem_d = is_signed && reg1_i[31];
            cnt_d     = '0;
            state_d   = S_BUSY;
          end else begin
            state_d = S_ZERO;
          end
        end
      end
      S_BUSY: begin
        rem_d = fits ? trial[31:0] : shifted[31:0];
        quo_d = {quo_q[30:0], fits};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      quo_q     <= 32'd0;
      rem_q     <= 32'd0;
      dvsr_q    <= 32'd0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      dvsr_q    <= dvsr_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
    end
  end

  always_comb begin
    case (aluop_i)
      OP_OR:   wdata_o = reg1_i | reg2_i;
      OP_AND:  wdata_o = reg1_i & reg2_i;
      OP_ADDU: wdata_o = reg1_i + reg2_i;
      OP_SUBU: wdata_o = reg1_i - reg2_i;
      OP_SLT:  wdata_o = ($signed(reg1_i) < $signed(reg2_i)) ? 32'd1 : 32'd0;
      OP_JAL:  wdata_o = link_address_i;
      OP_NOP:  wdata_o = 32'd0;
      default: wdata_o = 32'd0;
    endcase
  end

  assign wd_o              = wd_i;
  assign wreg_o            = wreg_i && !is_div;
  assign is_in_delayslot_o = is_in_delayslot_i;

  always_comb begin
    stallreq = 1'b0;
    whilo_o  = 1'b0;
    hi_o     = 32'd0;
    lo_o     = 32'd0;
    if (rst) begin
      case (state_q)
        S_IDLE: stallreq = is_div;
        S_BUSY: stallreq = 1'b1;
        S_DONE: begin
          whilo_o = 1'b1;
          lo_o    = neg_quo_q ? (~quo_q + 32'd1) : quo_q;
          hi_o    = neg_rem_q ? (~rem_q + 32'd1) : rem_q;
        end
        default: whilo_o = 1'b1;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ex_stage.sv
// Directed self-checking bench for ex_stage: ALU ops, divider latency and
// results, zero divisor, signed corner cases and reset during a divide.
`default_nettype none

module tb_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  aluop_i;
  logic [31:0] reg1_i, reg2_i, link_address_i;
  logic [4:0]  wd_i;
  logic        wreg_i, is_in_delayslot_i;
  logic [4:0]  wd_o;
  logic        wreg_o, whilo_o, is_in_delayslot_o, stallreq;
  logic [31:0] wdata_o, hi_o, lo_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ex_stage #(.DIV_CYCLES(32)) dut (
    .clk(clk), .rst(rst), .aluop_i(aluop_i), .reg1_i(reg1_i), .reg2_i(reg2_i),
    .wd_i(wd_i), .wreg_i(wreg_i), .link_address_i(link_address_i),
    .is_in_delayslot_i(is_in_delayslot_i), .wd_o(wd_o), .wreg_o(wreg_o),
    .wdata_o(wdata_o), .whilo_o(whilo_o), .hi_o(hi_o), .lo_o(lo_o),
    .is_in_delayslot_o(is_in_delayslot_o), .stallreq(stallreq)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic alu(input string tag, input logic [7:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp);
    step();
    aluop_i = op; reg1_i = a; reg2_i = b; wreg_i = 1'b1;
    #1;
    chk({tag, "_wdata"}, wdata_o, exp);
    chk({tag, "_wreg"}, {31'd0, wreg_o}, 32'd1);
    chk({tag, "_stall"}, {31'd0, stallreq}, 32'd0);
    chk({tag, "_whilo"}, {31'd0, whilo_o}, 32'd0);
  endtask

  task automatic run_div(input string tag, input logic [7:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int exp_cycles,
                         input logic [31:0] exp_lo, input logic [31:0] exp_hi);
    int cyc;
    step();
    aluop_i = op; reg1_i = a; reg2_i = b; wreg_i = 1'b1;
    #1;
    chk({tag, "_issue_stall"}, {31'd0, stallreq}, 32'd1);
    chk({tag, "_wreg_forced"}, {31'd0, wreg_o}, 32'd0);
    cyc = 0;
    while (stallreq === 1'b1 && cyc < 200) begin
      cyc++;
      step();
      // Operands must be ignored once the divide is under way.
      if (cyc == 1) begin
        reg1_i = $urandom;
        reg2_i = $urandom;
      end
    end
    chk({tag, "_stall_cycles"}, 32'(cyc), 32'(exp_cycles));
    chk({tag, "_whilo"}, {31'd0, whilo_o}, 32'd1);
    chk({tag, "_lo"}, lo_o, exp_lo);
    chk({tag, "_hi"}, hi_o, exp_hi);
  endtask

  initial begin
    rst = 1'b0; aluop_i = 8'h00; reg1_i = 32'd0; reg2_i = 32'd0;
    wd_i = 5'd9; wreg_i = 1'b0; link_address_i = 32'h0000_0108; is_in_delayslot_i = 1'b1;
    step();
    step();
    chk("rst_stall", {31'd0, stallreq}, 32'd0);
    chk("rst_whilo", {31'd0, whilo_o}, 32'd0);
    chk("rst_hilo", hi_o | lo_o, 32'd0);
    chk("pass_wd", {27'd0, wd_o}, 32'd9);
    chk("pass_ds", {31'd0, is_in_delayslot_o}, 32'd1);
    rst = 1'b1;

    alu("addu", 8'h21, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001);
    alu("slt",  8'h2A, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001);
    alu("slt0", 8'h2A, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000);
    alu("jal",  8'h50, 32'h1234_5678, 32'h0,         32'h0000_0108);
    alu("or",   8'h25, 32'hF0F0_0000, 32'h0000_0F0F, 32'hF0F0_0F0F);
    alu("and",  8'h24, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0F00_0F00);
    alu("subu", 8'h23, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF);
    alu("bad",  8'h77, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);

    run_div("divu_100_7", 8'h1B, 32'd100, 32'd7, 33, 32'd14, 32'd2);
    // Back-to-back: next divide issued on the cycle after DONE.
    run_div("div_m7_2",   8'h1A, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    run_div("div_7_m2",   8'h1A, 32'd7, 32'hFFFF_FFFE, 33, 32'hFFFF_FFFD, 32'd1);
    run_div("div_min_m1", 8'h1A, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h8000_0000, 32'd0);
    run_div("divu_big",   8'h1B, 32'hFFFF_FFFF, 32'h0000_0010, 33, 32'h0FFF_FFFF, 32'd15);
    run_div("divu_5_0",   8'h1B, 32'd5, 32'd0, 1, 32'd0, 32'd0);

    step();
    aluop_i = 8'h00;
    step();
    chk("idle_whilo", {31'd0, whilo_o}, 32'd0);

    // Reset partway through a divide.
    aluop_i = 8'h1B; reg1_i = 32'd1000; reg2_i = 32'd3;
    for (int i = 0; i < 10; i++) step();
    chk("busy_stall", {31'd0, stallreq}, 32'd1);
    rst = 1'b0;
    #1;
    chk("rst_mid_stall_comb", {31'd0, stallreq}, 32'd0);
    step();
    aluop_i = 8'h00;
    rst = 1'b1;
    #1;
    chk("post_rst_stall", {31'd0, stallreq}, 32'd0);
    chk("post_rst_whilo", {31'd0, whilo_o}, 32'd0);
    for (int i = 0; i < 40; i++) begin
      step();
      if (whilo_o !== 1'b0 || stallreq !== 1'b0) begin
        chk("post_rst_quiet", {30'd0, whilo_o, stallreq}, 32'd0);
        break;
      end
    end
    run_div("divu_9_3", 8'h1B, 32'd9, 32'd3, 33, 32'd3, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
